iob_knn_feeder: RTL and testbench

//  Native-interface bus master: the initiator for the KNN peripheral's native slave port.
//  On start it performs the following sequence:
//    - writes the test point to KNN DATA_1;
//    - streams n_points 32-bit packed points {y[31:16],x[15:0]} from memory into KNN DATA_2;
//    - polls KNN DONE until it is nonzero, then pulses done.

---
 rtl/iob_knn_feeder.sv | 189 ++++++++++++++++++
 tb/tb_iob_knn_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_knn_feeder.sv
// iob_knn_feeder
//   Native-interface bus master that feeds the KNN peripheral. On an
//   accepted start it:
//     1. writes the test point to DATA_1;
//     2. copies n_points packed {y,x} words from memory into DATA_2;
//     3. polls DONE until it reads nonzero, then pulses done.
//   If DONE stays zero for POLL_MAX reads, it sets the sticky timeout flag
//   and returns to idle.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                1-cycle request, accepted only in IDLE
//   test_point           {y,x} test point, sampled at accepted start
//   src_addr             byte address of the first dataset word
//   n_points             dataset length, sampled at accepted start
//   busy                 high while a sequence is in progress
//   done                 1-cycle pulse when DONE reads nonzero
//   timeout              sticky poll-timeout flag
//   m_valid/m_addr/m_wdata/m_wstrb   registered native request
//   m_rdata/m_ready      slave response (m_ready is a 1-cycle completion pulse)
module iob_knn_feeder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] KNN_BASE  = '0,
  parameter logic [ADDR_W-1:0] DATA1_OFF = ADDR_W'(4),
  parameter logic [ADDR_W-1:0] DATA2_OFF = ADDR_W'(8),
  parameter logic [ADDR_W-1:0] DONE_OFF  = ADDR_W'(12),
  parameter int                POLL_MAX  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     test_point,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [15:0]           n_points,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready
);

  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [ADDR_W-1:0] DATA1_ADDR = KNN_BASE + DATA1_OFF;
  localparam logic [ADDR_W-1:0] DATA2_ADDR = KNN_BASE + DATA2_OFF;
  localparam logic [ADDR_W-1:0] DONE_ADDR  = KNN_BASE + DONE_OFF;

  typedef enum logic [2:0] {IDLE, WR_TEST, RD_PT, WR_PT, POLL, FIN} state_t;

  state_t              state, state_nxt;
  logic                valid_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [DATA_W/8-1:0] wstrb_nxt;
  logic                timeout_nxt;
  logic [ADDR_W-1:0]   src_reg, src_nxt;
  logic [15:0]         npts_reg, npts_nxt;
  logic [15:0]         pt_cnt, pt_cnt_nxt, pt_inc;
  logic [PW-1:0]       poll_cnt, poll_cnt_nxt, poll_inc;

  assign busy = (state != IDLE) && (state != FIN);
  assign done = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      timeout  <= 1'b0;
      src_reg  <= '0;
      npts_reg <= '0;
      pt_cnt   <= '0;
      poll_cnt <= '0;
    end else begin
      state    <= state_nxt;
      m_valid  <= valid_nxt;
      m_addr   <= addr_nxt;
      m_wdata  <= wdata_nxt;
      m_wstrb  <= wstrb_nxt;
      timeout  <= timeout_nxt;
      src_reg  <= src_nxt;
      npts_reg <= npts_nxt;
      pt_cnt   <= pt_cnt_nxt;
      poll_cnt <= poll_cnt_nxt;
    end
  end

  // The next request is loaded in the same cycle the current one completes,
  // so requests run back-to-back. The captured dataset word is held directly
  // in m_wdata for the following DATA_2 write.
  always_comb begin
    state_nxt    = state;
    valid_nxt    = m_valid;
    addr_nxt     = m_addr;
    wdata_nxt    = m_wdata;
    wstrb_nxt    = m_wstrb;
    timeout_nxt  = timeout;
    src_nxt      = src_reg;
    npts_nxt     = npts_reg;
    pt_cnt_nxt   = pt_cnt;
    poll_cnt_nxt = poll_cnt;
    pt_inc       = pt_cnt + 16'd1;
    poll_inc     = poll_cnt + PW'(1);

    case (state)
      IDLE: begin
        if (start) begin
          timeout_nxt  = 1'b0;
          src_nxt      = src_addr;
          npts_nxt     = n_points;
          pt_cnt_nxt   = '0;
          poll_cnt_nxt = '0;
          valid_nxt    = 1'b1;
          addr_nxt     = DATA1_ADDR;
          wdata_nxt    = test_point;
          wstrb_nxt    = '1;
          state_nxt    = WR_TEST;
        end
      end
      WR_TEST: begin
        if (m_ready) begin
          wdata_nxt = '0;
          wstrb_nxt = '0;
          if (npts_reg == 16'd0) begin
            addr_nxt  = DONE_ADDR;
            state_nxt = POLL;
          end else begin
            addr_nxt  = src_reg;
            state_nxt = RD_PT;
          end
        end
      end
      RD_PT: begin
        if (m_ready) begin
          addr_nxt  = DATA2_ADDR;
          wdata_nxt = m_rdata;
          wstrb_nxt = '1;
          state_nxt = WR_PT;
        end
      end
      WR_PT: begin
        if (m_ready) begin
          pt_cnt_nxt = pt_inc;
          wdata_nxt  = '0;
          wstrb_nxt  = '0;
          if (pt_inc == npts_reg) begin
            addr_nxt  = DONE_ADDR;
            state_nxt = POLL;
          end else begin
            // Byte address wraps modulo 2^ADDR_W.
            addr_nxt  = src_reg + ADDR_W'({pt_inc, 2'b00});
            state_nxt = RD_PT;
          end
        end
      end
      POLL: begin
        if (m_ready) begin
          if (m_rdata != '0) begin
            valid_nxt = 1'b0;
            state_nxt = FIN;
          end else begin
            poll_cnt_nxt = poll_inc;
            if (poll_inc == PW'(POLL_MAX)) begin
              timeout_nxt = 1'b1;
              valid_nxt   = 1'b0;
              state_nxt   = IDLE;
            end
            // Otherwise m_valid stays high and the same DONE read reissues.
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_knn_feeder.sv
// tb_iob_knn_feeder
//   Randomized bench for iob_knn_feeder. A behavioural slave answers every
//   request after a random number of wait cycles and logs completed
//   transactions. A reference model builds the expected transaction list
//   from the feeder's job description, and the bench compares it with the
//   slave's log.
module tb_iob_knn_feeder;

  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam logic [31:0] DATA1_A = BASE + 32'h4;
  localparam logic [31:0] DATA2_A = BASE + 32'h8;
  localparam logic [31:0] DONE_A  = BASE + 32'hC;
  localparam int          PMAX    = 4;
  localparam int          BOUND   = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] test_point;
  logic [31:0] src_addr;
  logic [15:0] n_points;
  logic        busy, done, timeout;
  logic        m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;

  iob_knn_feeder #(
    .ADDR_W(32), .DATA_W(32), .KNN_BASE(BASE),
    .DATA1_OFF(32'h4), .DATA2_OFF(32'h8), .DONE_OFF(32'hC), .POLL_MAX(PMAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .test_point(test_point),
    .src_addr(src_addr), .n_points(n_points), .busy(busy), .done(done),
    .timeout(timeout), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Job-wide settings shared by the slave and the model.
  logic [31:0] cur_src;
  int          done_after;
  int          polls_seen;
  int          max_wait;
  int          done_cnt;

  logic [31:0] log_addr[$], log_wdata[$];
  logic [3:0]  log_wstrb[$];
  logic [31:0] exp_addr[$], exp_wdata[$];
  logic [3:0]  exp_wstrb[$];

  // Memory contents: word i of the dataset is {2i+2, 2i+1}.
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] i;
    i = (a - cur_src) >> 2;
    return {16'(2 * i + 2), 16'(2 * i + 1)};
  endfunction

  // Behavioural slave.
  initial begin : slave
    logic        armed;
    int          wl;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    armed = 1'b0; wl = 0;
    s_addr = '0; s_wdata = '0; s_wstrb = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      m_ready = 1'b0;
      m_rdata = $urandom;
      if (rst) begin
        armed = 1'b0;
      end else if (!armed && m_valid) begin
        armed   = 1'b1;
        wl      = $urandom_range(0, max_wait);
        s_addr  = m_addr;
        s_wdata = m_wdata;
        s_wstrb = m_wstrb;
      end else if (armed) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_addr", m_addr, s_addr);
        check("hold_wdata", m_wdata, s_wdata);
        check("hold_wstrb", 32'(m_wstrb), 32'(s_wstrb));
        if (wl == 0) begin
          m_ready = 1'b1;
          armed   = 1'b0;
          if (s_wstrb == 4'h0) begin
            if (s_addr == DONE_A) begin
              polls_seen++;
              m_rdata = (polls_seen > done_after) ? 32'h1 : 32'h0;
            end else begin
              m_rdata = mem(s_addr);
            end
          end
          log_addr.push_back(s_addr);
          log_wdata.push_back(s_wdata);
          log_wstrb.push_back(s_wstrb);
        end else begin
          wl--;
        end
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic build_model(input logic [31:0] tp, input logic [31:0] src,
                             input int n, input int da);
    int polls;
    exp_addr.delete(); exp_wdata.delete(); exp_wstrb.delete();
    exp_addr.push_back(DATA1_A); exp_wdata.push_back(tp); exp_wstrb.push_back(4'hF);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = src + 32'(4 * i);
      exp_addr.push_back(a);       exp_wdata.push_back('0);     exp_wstrb.push_back(4'h0);
      exp_addr.push_back(DATA2_A); exp_wdata.push_back(mem(a)); exp_wstrb.push_back(4'hF);
    end
    polls = (da < PMAX) ? da + 1 : PMAX;
    for (int i = 0; i < polls; i++) begin
      exp_addr.push_back(DONE_A); exp_wdata.push_back('0); exp_wstrb.push_back(4'h0);
    end
  endtask

  task automatic compare_logs();
    int m;
    check("txn_count", 32'(log_addr.size()), 32'(exp_addr.size()));
    m = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("txn%0d_addr", i), log_addr[i], exp_addr[i]);
      check($sformatf("txn%0d_wstrb", i), 32'(log_wstrb[i]), 32'(exp_wstrb[i]));
      if (exp_wstrb[i] == 4'hF)
        check($sformatf("txn%0d_wdata", i), log_wdata[i], exp_wdata[i]);
    end
  endtask

  task automatic clear_job(input logic [31:0] src, input int da);
    cur_src = src; done_after = da; polls_seen = 0; done_cnt = 0;
    log_addr.delete(); log_wdata.delete(); log_wstrb.delete();
  endtask

  task automatic run_case(input logic [31:0] tp, input logic [31:0] src, input int n,
                          input int da, input bit sec_start, input bit fin_start);
    int   cyc;
    logic exp_done;
    clear_job(src, da);
    build_model(tp, src, n, da);
    exp_done = (da < PMAX);
    @(posedge clk); #2;
    test_point = tp; src_addr = src; n_points = 16'(n); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("timeout_clr_at_start", 32'(timeout), 32'd0);
    check("busy_rise", 32'(busy), 32'd1);
    cyc = 0;
    while (busy && cyc < BOUND) begin
      @(posedge clk); #2;
      cyc++;
      if (sec_start && cyc == 3) begin
        start = 1'b1; n_points = 16'(n + 3); src_addr = src + 32'h40; test_point = ~tp;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("cycle_bound", 32'(cyc < BOUND), 32'd1);
    check("done_with_busy_fall", 32'(done), 32'(exp_done));
    if (fin_start && exp_done) begin
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("idle_busy", 32'(busy), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'(exp_done));
    check("timeout_flag", 32'(timeout), 32'(!exp_done));
    compare_logs();
  endtask

  initial begin : main
    int cyc;
    rst = 1'b1; start = 1'b0; test_point = '0; src_addr = '0; n_points = '0;
    max_wait = 0; cur_src = '0; done_after = 0; polls_seen = 0; done_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_addr", m_addr, 32'd0);
    check("rst_wdata", m_wdata, 32'd0);
    check("rst_wstrb", 32'(m_wstrb), 32'd0);
    rst = 1'b0;

    // Zero-wait slave, 3 points, DONE on the 2nd poll, start during FIN.
    max_wait = 0;
    run_case(32'h0011_0022, 32'h100, 3, 1, 1'b0, 1'b1);
    // Random waits.
    max_wait = 5;
    run_case($urandom, 32'h200, 4, 0, 1'b0, 1'b0);
    // No dataset points.
    run_case($urandom, 32'h300, 0, 2, 1'b0, 1'b0);
    // DONE never set: timeout, then a fresh start clears it.
    run_case($urandom, 32'h400, 1, 100, 1'b0, 1'b0);
    run_case($urandom, 32'h500, 1, 0, 1'b0, 1'b0);
    // Address wrap.
    run_case($urandom, 32'hFFFF_FFFC, 2, 1, 1'b0, 1'b0);
    // Second start while busy is ignored.
    run_case($urandom, 32'h600, 3, 1, 1'b1, 1'b0);

    // Reset while a DATA_2 write is outstanding.
    clear_job(32'h2000, 0);
    @(posedge clk); #2;
    test_point = $urandom; src_addr = 32'h2000; n_points = 16'd4; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (!(m_valid && m_wstrb == 4'hF && m_addr == DATA2_A) && cyc < BOUND) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("wr_pt_reached", 32'(cyc < BOUND), 32'd1);
    rst = 1'b1;
    #1;
    check("hz_valid", 32'(m_valid), 32'd0);
    check("hz_busy", 32'(busy), 32'd0);
    check("hz_done", 32'(done), 32'd0);
    check("hz_timeout", 32'(timeout), 32'd0);
    check("hz_addr", m_addr, 32'd0);
    check("hz_wdata", m_wdata, 32'd0);
    check("hz_wstrb", 32'(m_wstrb), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    run_case($urandom, 32'h3000, 2, 1, 1'b0, 1'b0);

    // Randomized jobs.
    for (int k = 0; k < 8; k++) begin
      max_wait = $urandom_range(0, 5);
      run_case($urandom, $urandom & 32'h0FFF_FFFC, $urandom_range(0, 6),
               $urandom_range(0, 5), 1'(k % 3 == 0), 1'(k % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
